// File: rtl/aes_block_loader_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES-128 block loader.
//   AES_BLK_W    : block / key width (128)
//   AES_WORD_W   : plaintext stream word width (32)
//   AES_START_TO : default cycles allowed in WAIT_LOW for core_ready to fall
//   aes_state_e  : loader FSM states
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLK_W    = 128;
   localparam int AES_WORD_W   = 32;
   localparam int AES_START_TO = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_LOW,
      WAIT_HIGH
   } aes_state_e;

endpackage

// File: rtl/aes_block_loader_if.sv
// -----------------------------------------------------------------------------
// Interfaces of the AES block loader.
//   aes_stream_if : 32-bit plaintext word stream, valid/ready.
//                   master = word source, slave = loader.
//   aes_core_if   : start/ready handshake plus block and key to the AES core.
//                   master = loader, slave = core.
// -----------------------------------------------------------------------------
interface aes_stream_if;
   import aes_pkg::*;

   logic                  s_valid;
   logic                  s_ready;
   logic [AES_WORD_W-1:0] s_data;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

interface aes_core_if;
   import aes_pkg::*;

   logic                 core_start;
   logic                 core_ready;
   logic [AES_BLK_W-1:0] core_data;
   logic [AES_BLK_W-1:0] core_key;

   modport master (output core_start, output core_data, output core_key,
                   input  core_ready);
   modport slave  (input  core_start, input  core_data, input  core_key,
                   output core_ready);
endinterface

// File: rtl/aes_block_loader_packer.sv
// -----------------------------------------------------------------------------
// aes_word_packer
// Assembles four 32-bit stream words into one 128-bit block, MSW first
// (word0 -> [127:96], word3 -> [31:0]). Once four words are in, the buffer
// reports full and stops accepting until the owner takes the block.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   s        : word stream (slave side); s_ready = !full
//   i_take   : owner copies o_fill this cycle; clears full
//   o_fill   : assembled block
//   o_full   : four words present, waiting to be taken
// -----------------------------------------------------------------------------
module aes_word_packer
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   aes_stream_if.slave          s,
   input  logic                 i_take,
   output logic [AES_BLK_W-1:0] o_fill,
   output logic                 o_full
);

   logic [AES_BLK_W-1:0] r_fill;
   logic [1:0]           r_cnt;
   logic                 r_full;
   logic                 w_accept;

   // Ready comes straight from the full flop: no same-cycle bypass.
   assign s.s_ready = ~r_full;
   assign w_accept  = s.s_valid & ~r_full;
   assign o_fill    = r_fill;
   assign o_full    = r_full;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values and simulation matches the synthesized registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fill <= '0;
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else if (w_accept) begin
         r_fill <= {r_fill[AES_BLK_W-AES_WORD_W-1:0], s.s_data};
         r_cnt  <= r_cnt + 2'd1;
         if (r_cnt == 2'd3) begin
            r_full <= 1'b1;
         end
      end else if (i_take) begin
         // Take only happens while full, when no word can be accepted.
         r_full <= 1'b0;
      end
   end

endmodule

// File: rtl/aes_block_loader.sv
// -----------------------------------------------------------------------------
// aes_block_loader
// Feeds the AES-128 core: packs the plaintext stream into blocks, double
// buffers them (fill buffer in the packer, hold buffer here), holds the key,
// pulses core_start and tracks the core's ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   s_if        : plaintext word stream (slave)
//   core_if     : start/ready handshake, block and key to the core (master)
//   key_load    : load key_in; honoured only in IDLE
//   key_in      : cipher key
//   busy        : hold buffer in use (state != IDLE)
//   blk_done    : one-cycle pulse when the core returns to ready
//   err_timeout : one-cycle pulse when core_ready never fell after start
//   key_err     : one-cycle pulse when key_load was ignored
//   blk_count   : completed blocks, wraps
// -----------------------------------------------------------------------------
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int START_TO = AES_START_TO,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_stream_if.slave          s_if,
   aes_core_if.master           core_if,
   input  logic                 key_load,
   input  logic [AES_BLK_W-1:0] key_in,
   output logic                 busy,
   output logic                 blk_done,
   output logic                 err_timeout,
   output logic                 key_err,
   output logic [CNT_W-1:0]     blk_count
);

   localparam int TO_W = $clog2(START_TO + 1);

   aes_state_e           r_state, w_state_nxt;
   logic [AES_BLK_W-1:0] r_hold;
   logic [AES_BLK_W-1:0] r_key;
   logic [TO_W-1:0]      r_to_cnt;
   logic                 r_done;
   logic                 r_timeout;
   logic                 r_key_err;
   logic [CNT_W-1:0]     r_blk_count;

   logic [AES_BLK_W-1:0] w_fill;
   logic                 w_fill_full;
   logic                 w_take;
   logic                 w_done;
   logic                 w_timeout;
   logic                 w_to_clr;
   logic                 w_to_inc;

   aes_word_packer u_packer (
      .clk    (clk),
      .rst    (rst),
      .s      (s_if),
      .i_take (w_take),
      .o_fill (w_fill),
      .o_full (w_fill_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      w_to_clr    = 1'b0;
      w_to_inc    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fill_full) begin
               w_take      = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            w_to_clr    = 1'b1;
            w_state_nxt = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!core_if.core_ready) begin
               w_state_nxt = WAIT_HIGH;
            end else if (r_to_cnt == TO_W'(START_TO - 1)) begin
               // START_TO-th cycle in WAIT_LOW with the core still idle.
               w_timeout   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_to_inc = 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (core_if.core_ready) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: hold and key are plain flop registers, not RAM, so they are reset;
   // the core then sees zeros rather than stale data after a reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold      <= '0;
         r_key       <= '0;
         r_to_cnt    <= '0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_key_err   <= 1'b0;
         r_blk_count <= '0;
      end else begin
         // Hold is only written on the IDLE transfer, so core_data is stable
         // for the whole core run.
         if (w_take) r_hold <= w_fill;
         if (key_load && (r_state == IDLE)) r_key <= key_in;
         if (w_to_clr)      r_to_cnt <= '0;
         else if (w_to_inc) r_to_cnt <= r_to_cnt + TO_W'(1);
         r_done    <= w_done;
         r_timeout <= w_timeout;
         r_key_err <= key_load && (r_state != IDLE);
         if (w_done) r_blk_count <= r_blk_count + CNT_W'(1);
      end
   end

   // START lasts exactly one cycle and is always followed by a WAIT state,
   // giving a single start pulse with a low gap before the next one.
   assign core_if.core_start = (r_state == START);
   assign core_if.core_data  = r_hold;
   assign core_if.core_key   = r_key;
   assign busy               = (r_state != IDLE);
   assign blk_done           = r_done;
   assign err_timeout        = r_timeout;
   assign key_err            = r_key_err;
   assign blk_count          = r_blk_count;

endmodule

// File: tb/tb_aes_block_loader.sv
// -----------------------------------------------------------------------------
// tb_aes_block_loader
// Directed bench for aes_block_loader with a small AES core handshake model.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_aes_block_loader;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_load;
   logic [127:0] key_in;
   logic         busy, blk_done, err_timeout, key_err;
   logic [15:0]  blk_count;

   aes_stream_if s_if ();
   aes_core_if   c_if ();

   aes_block_loader dut (
      .clk         (clk),
      .rst         (rst),
      .s_if        (s_if),
      .core_if     (c_if),
      .key_load    (key_load),
      .key_in      (key_in),
      .busy        (busy),
      .blk_done    (blk_done),
      .err_timeout (err_timeout),
      .key_err     (key_err),
      .blk_count   (blk_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Core model: 2 cycles after seeing start it drops ready, 10 cycles later
   // it raises it again. With core_mode = 0 it ignores start (ready stays 1).
   int core_mode = 1;
   int core_t    = -1;
   initial begin
      c_if.core_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (core_mode != 0 && c_if.core_start) core_t = 0;
         else if (core_t >= 0) core_t++;
         if (core_t == 2) c_if.core_ready = 1'b0;
         if (core_t == 12) begin
            c_if.core_ready = 1'b1;
            core_t = -1;
         end
      end
   end

   // Start monitor: records each presented block and counts start pulses
   // lasting more than one cycle.
   logic [127:0] cap_q[$];
   logic         prev_start = 1'b0;
   int           dbl_start  = 0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (c_if.core_start) begin
            cap_q.push_back(c_if.core_data);
            if (prev_start) dbl_start++;
         end
         prev_start = c_if.core_start;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   function automatic logic probe(input int sel);
      case (sel)
         0:       return c_if.core_start;
         1:       return c_if.core_ready;
         2:       return blk_done;
         3:       return err_timeout;
         default: return busy;
      endcase
   endfunction

   // Wait (on falling edges) until the selected signal equals val; n = edges waited.
   task automatic wait_for(input int sel, input logic val, input string tag, output int n);
      n = 0;
      while (probe(sel) !== val && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check(tag, probe(sel), val);
   endtask

   // Present one word; returns on the falling edge after it was accepted.
   task automatic send_word(input logic [31:0] w);
      int n;
      s_if.s_valid = 1'b1;
      s_if.s_data  = w;
      n = 0;
      while (!s_if.s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_stall", s_if.s_ready, 1'b1);
      @(negedge clk);
   endtask

   task automatic send_block(input logic [127:0] b);
      for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32]);
      s_if.s_valid = 1'b0;
   endtask

   task automatic reset_checks(input string p);
      check({p, "_start"},   c_if.core_start, 1'b0);
      check({p, "_data"},    c_if.core_data,  '0);
      check({p, "_key"},     c_if.core_key,   '0);
      check({p, "_busy"},    busy,            1'b0);
      check({p, "_done"},    blk_done,        1'b0);
      check({p, "_tmo"},     err_timeout,     1'b0);
      check({p, "_keyerr"},  key_err,         1'b0);
      check({p, "_count"},   blk_count,       '0);
      check({p, "_s_ready"}, s_if.s_ready,    1'b1);
   endtask

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
   localparam logic [127:0] K3 = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B2 = 128'h11111111222222223333333344444444;
   localparam logic [127:0] B3 = 128'ha5a5a5a55a5a5a5af0f0f0f00f0f0f0f;
   localparam logic [127:0] B4 = 128'h0badf00d0badf00d0badf00d0badf00d;
   localparam logic [127:0] B5 = 128'h01234567890abcdeffedcba987654321;
   localparam logic [127:0] B6 = 128'hcafebabe13579bdf2468ace0fedcba98;

   initial begin
      int n, m;
      logic [127:0] exp_blk;
      rst = 1'b1;
      key_load = 1'b0;
      key_in = '0;
      s_if.s_valid = 1'b0;
      s_if.s_data = '0;
      repeat (3) @(negedge clk);
      reset_checks("por");
      rst = 1'b0;
      @(negedge clk);

      // Single block with key load.
      key_load = 1'b1;
      key_in = K1;
      @(negedge clk);
      key_load = 1'b0;
      check("t1_key", c_if.core_key, K1);
      send_block(B1);
      check("t1_full_ready", s_if.s_ready, 1'b0);
      wait_for(0, 1'b1, "t1_start_wait", n);
      check("t1_start_lat", n, 1);
      check("t1_data", c_if.core_data, B1);
      check("t1_core_key", c_if.core_key, K1);
      @(negedge clk);
      check("t1_start_pulse", c_if.core_start, 1'b0);
      wait_for(2, 1'b1, "t1_done_wait", n);
      check("t1_count", blk_count, 16'd1);
      @(negedge clk);
      check("t1_done_pulse", blk_done, 1'b0);

      // Overlap: ignored key_load in WAIT_HIGH, next block streamed during
      // the run, key loaded on the transfer edge.
      send_block(B2);
      wait_for(0, 1'b1, "t2_start_wait", n);
      check("t2_data", c_if.core_data, B2);
      wait_for(1, 1'b0, "t2_low_wait", n);
      @(negedge clk);
      key_load = 1'b1;
      key_in = K2;
      @(negedge clk);
      key_load = 1'b0;
      check("t2_key_err", key_err, 1'b1);
      check("t2_key_kept", c_if.core_key, K1);
      @(negedge clk);
      check("t2_key_err_pulse", key_err, 1'b0);
      send_block(B3);
      check("t2_full_ready", s_if.s_ready, 1'b0);
      check("t2_data_stable", c_if.core_data, B2);
      check("t2_busy", busy, 1'b1);
      wait_for(1, 1'b1, "t2_high_wait", n);
      wait_for(2, 1'b1, "t2_done_wait", n);
      key_load = 1'b1;
      key_in = K3;
      check("t2_count", blk_count, 16'd2);
      wait_for(0, 1'b1, "t2_start2_wait", m);
      key_load = 1'b0;
      check("t2_ready_to_start", n + m, 2);
      check("t2_data2", c_if.core_data, B3);
      check("t2_key_transfer", c_if.core_key, K3);
      @(negedge clk);
      wait_for(2, 1'b1, "t2_done2_wait", n);
      check("t2_count2", blk_count, 16'd3);
      @(negedge clk);

      // Backpressure: 12 words with s_valid held high.
      cap_q.delete();
      for (int i = 0; i < 12; i++) begin
         send_word(32'hc0de0000 + 32'(i));
         if (i % 4 == 3) check("t3_ready_drop", s_if.s_ready, 1'b0);
      end
      s_if.s_valid = 1'b0;
      n = 0;
      while (blk_count != 16'd6 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("t3_count", blk_count, 16'd6);
      check("t3_nblocks", cap_q.size(), 3);
      for (int j = 0; j < 3 && j < cap_q.size(); j++) begin
         for (int k = 0; k < 4; k++)
            exp_blk[127-32*k -: 32] = 32'hc0de0000 + 32'(4*j + k);
         check("t3_block", cap_q[j], exp_blk);
      end
      check("t3_single_pulses", dbl_start, 0);

      // Timeout: core never drops ready.
      core_mode = 0;
      @(negedge clk);
      send_block(B4);
      wait_for(0, 1'b1, "t4_start_wait", n);
      wait_for(3, 1'b1, "t4_tmo_wait", n);
      check("t4_tmo_lat", n, 5);
      check("t4_idle", busy, 1'b0);
      check("t4_count", blk_count, 16'd6);
      @(negedge clk);
      check("t4_tmo_pulse", err_timeout, 1'b0);
      core_mode = 1;

      // Reset in WAIT_HIGH with two words of the next block buffered.
      send_block(B5);
      wait_for(0, 1'b1, "t5_start_wait", n);
      wait_for(1, 1'b0, "t5_low_wait", n);
      @(negedge clk);
      send_word(32'h77777777);
      send_word(32'h88888888);
      s_if.s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      reset_checks("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      reset_checks("rst_rel");
      wait_for(1, 1'b1, "t5_high_wait", n);
      send_block(B6);
      wait_for(0, 1'b1, "t5_start2_wait", n);
      check("t5_data_realigned", c_if.core_data, B6);
      wait_for(2, 1'b1, "t5_done_wait", n);
      check("t5_count", blk_count, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the AES-128 encryption core.
- Accepts the plaintext stream as 32-bit words with valid/ready and assembles them into 128-bit blocks.
- Double-buffers the blocks so the next block can fill while the core runs.
- Holds the round key, issues the core's start pulse, tracks the core's ready handshake, and reports block completion and core timeouts.

Parameters:
- WORD_W, 32, input word width; fixed at 32, BLK_W/WORD_W = 4 words per block.
- BLK_W, 128, block and key width.
- START_TO, 4, maximum cycles allowed in WAIT_LOW for core_ready to fall.
- CNT_W, 16, width of blk_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  plaintext word; first word of a block is bits [127:96].
- key_load  in  1  load key_in into the key register.
- key_in  in  128  cipher key.
- core_start  out  1  one-cycle start pulse to the core.
- core_ready  in  1  core idle flag; 1 = idle.
- core_data  out  128  block presented to the core.
- core_key  out  128  key presented to the core.
- busy  out  1  hold buffer in use (state != IDLE).
- blk_done  out  1  one-cycle pulse when the core returns to ready.
- err_timeout  out  1  one-cycle pulse on core timeout.
- key_err  out  1  one-cycle pulse when key_load is ignored.
- blk_count  out  CNT_W  completed blocks, wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - All outputs 0, except s_ready, which is 1 after reset.
  - fill buffer, word count, hold buffer, key register, timeout counter and blk_count cleared; state = IDLE.
  - Reset mid-operation aborts everything with no pulse.
- Fill buffer:
  - A word is accepted on an edge where s_valid & s_ready.
  - Words shift in MSW-first: word0 -> [127:96], word3 -> [31:0].
  - A 2-bit counter wraps 3 -> 0 and sets fill_full.
  - s_ready = !fill_full, registered-derived. There is no same-cycle bypass, so s_ready stays 0 in the transfer cycle.
- Latency: core_start goes high in the cycle after the edge that accepted word3, provided state is IDLE.
- FSM states: IDLE, START, WAIT_LOW, WAIT_HIGH.
  - IDLE & fill_full: at the edge, hold <= fill, fill_full <= 0, core_start <= 1, go to START.
  - START: at the edge, core_start <= 0, timeout counter <= 0, go to WAIT_LOW.
  - WAIT_LOW:
    - core_ready == 0 -> go to WAIT_HIGH.
    - Otherwise the counter increments; at START_TO -> err_timeout pulse, hold released, blk_count unchanged, go to IDLE.
  - WAIT_HIGH: core_ready == 1 -> blk_done pulse, blk_count++, go to IDLE. There is no timeout in this state.
- Back-to-back blocks: core_start must be low for at least one cycle between pulses. This is guaranteed by the START -> WAIT_* path, since the core detects start by rising edge.
- core_data and core_key:
  - Driven directly from the hold register and the key register.
  - Must be stable from core_start high until core_ready returns high. The hold register is written only in IDLE.
- Key loading:
  - key_load is accepted only in IDLE and takes effect at that edge.
  - If key_load coincides with the transfer edge, the new key applies to that block.
  - key_load in any other state is ignored, with a key_err pulse in the following cycle.
- Filling while the core runs: the fill buffer keeps accepting words in every state. A full fill buffer simply waits for IDLE.
- Simultaneous blk_done and a pending full fill:
  - The return to IDLE happens at that edge.
  - The transfer happens at the next edge, so core_start rises 2 cycles after core_ready rises.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLK_W = 128 and AES_WORD_W = 32;
  - the FSM state enum (IDLE, START, WAIT_LOW, WAIT_HIGH);
  - the default START_TO.
- One natural sub-module, aes_word_packer: the 4-word shift register, counter and fill_full flag with the valid/ready interface. The FSM, hold register and key register stay in the top.

Test Plan:
- Single block:
  - Stimulus: key_load with key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff on consecutive cycles. The core model drops ready 2 cycles after start and raises it 10 cycles later.
  - Required response: core_data = 00112233445566778899aabbccddeeff; core_start is a single pulse one cycle after word3. blk_done follows with blk_count = 1.
- Overlap:
  - Stimulus: a second block streamed during WAIT_HIGH.
  - Required response: all 4 words accepted, then s_ready = 0. core_start rises 2 cycles after core_ready rises; core_data stays unchanged during the first run.
- Backpressure:
  - Stimulus: s_valid held high for 12 words continuously.
  - Required response: s_ready drops after each 4th word until transfer. No word is lost or duplicated, and the blocks are seen in order.
- Timeout:
  - Stimulus: the core model holds core_ready = 1.
  - Required response: err_timeout pulses 4 cycles after WAIT_LOW is entered, then the FSM is in IDLE with blk_count unchanged.
- Key rules:
  - Stimulus: key_load in WAIT_HIGH.
  - Required response: key_err pulses and core_key is unchanged. A key_load on the transfer edge applies the new key to that block.
- Reset:
  - Stimulus: rst asserted in WAIT_HIGH after 2 words of the next block have been filled.
  - Required response: all outputs 0 and s_ready = 1 after release. Words restart at the [127:96] position.
